// File: rtl/vga_scanout.sv
// vga_scanout: 640x480@60 VGA raster generator and frame-buffer reader.
// It produces the pixel clock enable, the h/v counters and the VRAM port B address.
// It drives registered RGB444 and sync outputs, one pixel period behind the counters.
// It also produces a one-clock frame tick at the start of vertical blank.
module vga_scanout #(
    parameter int CLK_DIV = 4,
    parameter int H_VIS   = 640,
    parameter int H_FP    = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int V_VIS   = 480,
    parameter int V_FP    = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33
) (
    input  logic        clk,
    input  logic        rst,
    output logic [18:0] vram_addr,
    input  logic [11:0] vram_data,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vblank,
    output logic        frame_tick
);

    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [3:0] DIV_LAST     = 4'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST       = 10'(H_TOT - 1);
    localparam logic [9:0] V_LAST       = 10'(V_TOT - 1);
    localparam logic [9:0] H_VIS_END    = 10'(H_VIS);
    localparam logic [9:0] V_VIS_END    = 10'(V_VIS);
    localparam logic [9:0] V_VIS_LAST   = 10'(V_VIS - 1);
    localparam logic [9:0] H_SYNC_BEG   = 10'(H_VIS + H_FP);
    localparam logic [9:0] H_SYNC_END   = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0] V_SYNC_BEG   = 10'(V_VIS + V_FP);
    localparam logic [9:0] V_SYNC_END   = 10'(V_VIS + V_FP + V_SYNC);

    logic [3:0]  div_r;
    logic [9:0]  h_r;
    logic [9:0]  v_r;
    logic [18:0] addr_r;
    logic [11:0] rgb_r;
    logic        hs_r;
    logic        vs_r;
    logic        tick_r;

    logic        pix_ce_s;
    logic [9:0]  h_next_s;
    logic [9:0]  v_next_s;
    logic        vis_cur_s;
    logic        vis_next_s;
    logic        next_origin_s;
    logic        hs_act_s;
    logic        vs_act_s;
    logic        tick_set_s;

    // Next raster position, visibility of current/next pixel and sync windows.
    always_comb begin
        pix_ce_s = (div_r == DIV_LAST);
        h_next_s = h_r;
        v_next_s = v_r;
        if (h_r == H_LAST) begin
            h_next_s = 10'd0;
            if (v_r == V_LAST) begin
                v_next_s = 10'd0;
            end else begin
                v_next_s = v_r + 10'd1;
            end
        end else begin
            h_next_s = h_r + 10'd1;
            v_next_s = v_r;
        end
        vis_cur_s     = (h_r < H_VIS_END) && (v_r < V_VIS_END);
        vis_next_s    = (h_next_s < H_VIS_END) && (v_next_s < V_VIS_END);
        next_origin_s = (h_next_s == 10'd0) && (v_next_s == 10'd0);
        hs_act_s      = (h_r >= H_SYNC_BEG) && (h_r < H_SYNC_END);
        vs_act_s      = (v_r >= V_SYNC_BEG) && (v_r < V_SYNC_END);
        // Last pixel of the last visible line is ending: next pixel opens vblank.
        tick_set_s    = pix_ce_s && (h_r == H_LAST) && (v_r == V_VIS_LAST);
    end

    // Pixel-rate divider: wraps at CLK_DIV-1, which is also the pixel enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_r <= 4'd0;
        end else if (pix_ce_s) begin
            div_r <= 4'd0;
        end else begin
            div_r <= div_r + 4'd1;
        end
    end

    // Horizontal and vertical counters; both wraps can occur on one enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_r <= 10'd0;
            v_r <= 10'd0;
        end else if (pix_ce_s) begin
            h_r <= h_next_s;
            v_r <= v_next_s;
        end else begin
            h_r <= h_r;
            v_r <= v_r;
        end
    end

    // Incrementing VRAM address: restarts at the origin, holds through blanking.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_r <= 19'd0;
        end else if (pix_ce_s) begin
            if (next_origin_s) begin
                addr_r <= 19'd0;
            end else if (vis_next_s) begin
                addr_r <= addr_r + 19'd1;
            end else begin
                addr_r <= addr_r;
            end
        end else begin
            addr_r <= addr_r;
        end
    end

    // Output stage: capture colour and sync of the pixel period that is ending.
    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_r <= 12'd0;
            hs_r  <= 1'b1;
            vs_r  <= 1'b1;
        end else if (pix_ce_s) begin
            rgb_r <= vis_cur_s ? vram_data : 12'd0;
            hs_r  <= ~hs_act_s;
            vs_r  <= ~vs_act_s;
        end else begin
            rgb_r <= rgb_r;
            hs_r  <= hs_r;
            vs_r  <= vs_r;
        end
    end

    // One-clock frame tick, coincident with the first clock of vblank.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_r <= 1'b0;
        end else begin
            tick_r <= tick_set_s;
        end
    end

    assign vram_addr  = addr_r;
    assign vga_r      = rgb_r[11:8];
    assign vga_g      = rgb_r[7:4];
    assign vga_b      = rgb_r[3:0];
    assign vga_hs     = hs_r;
    assign vga_vs     = vs_r;
    assign vblank     = (v_r >= V_VIS_END);
    assign frame_tick = tick_r;

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: directed bench with two instances sharing one clock.
// Instance A uses the full 640x480 timing at CLK_DIV=4 for line-level checks.
// Instance B uses a tiny raster at CLK_DIV=3 so that whole frames fit the run.
module tb_vga_scanout;

    logic        clk;
    logic        rst;

    logic [18:0] vram_addr_a;
    logic [11:0] vram_data_a;
    logic [3:0]  vga_r_a, vga_g_a, vga_b_a;
    logic        vga_hs_a, vga_vs_a, vblank_a, frame_tick_a;

    logic [18:0] vram_addr_b;
    logic [11:0] vram_data_b;
    logic [3:0]  vga_r_b, vga_g_b, vga_b_b;
    logic        vga_hs_b, vga_vs_b, vblank_b, frame_tick_b;

    int compared;
    int mismatched;

    vga_scanout dut_a (
        .clk        (clk),
        .rst        (rst),
        .vram_addr  (vram_addr_a),
        .vram_data  (vram_data_a),
        .vga_r      (vga_r_a),
        .vga_g      (vga_g_a),
        .vga_b      (vga_b_a),
        .vga_hs     (vga_hs_a),
        .vga_vs     (vga_vs_a),
        .vblank     (vblank_a),
        .frame_tick (frame_tick_a)
    );

    vga_scanout #(
        .CLK_DIV(3),
        .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_VIS(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) dut_b (
        .clk        (clk),
        .rst        (rst),
        .vram_addr  (vram_addr_b),
        .vram_data  (vram_data_b),
        .vga_r      (vga_r_b),
        .vga_g      (vga_g_b),
        .vga_b      (vga_b_b),
        .vga_hs     (vga_hs_b),
        .vga_vs     (vga_vs_b),
        .vblank     (vblank_b),
        .frame_tick (frame_tick_b)
    );

    // 100 MHz system clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // VRAM models: one clock of read latency, data = low 12 address bits.
    always @(posedge clk) begin
        vram_data_a <= vram_addr_a[11:0];
        vram_data_b <= vram_addr_b[11:0];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Expected address of raster position (h,v): live while visible, held otherwise.
    function automatic int exp_addr(input int h, input int v, input int hv, input int vv);
        if (v >= vv) begin
            return hv * vv - 1;
        end else if (h >= hv) begin
            return v * hv + hv - 1;
        end else begin
            return v * hv + h;
        end
    endfunction

    // Reference model of all outputs k clocks after reset release.
    task automatic cycle_check(input int k, input int cd,
                               input int hv, input int hf, input int hsw, input int hb,
                               input int vv, input int vf, input int vsw, input int vb,
                               input logic [18:0] oa, input logic [11:0] orgb,
                               input logic ohs, input logic ovs, input logic ovb,
                               input logic otk, output int nbad);
        int ht, vt, p, h, v, q, hq, vq, ea, er, ehs, evs, evb, etk;
        ht = hv + hf + hsw + hb;
        vt = vv + vf + vsw + vb;
        p  = k / cd;
        h  = p % ht;
        v  = (p / ht) % vt;
        ea  = exp_addr(h, v, hv, vv);
        evb = (v >= vv) ? 1 : 0;
        etk = (k > 0 && (k % cd) == 0 && (p % (ht * vt)) == vv * ht) ? 1 : 0;
        if (p == 0) begin
            er  = 0;
            ehs = 1;
            evs = 1;
        end else begin
            q   = p - 1;
            hq  = q % ht;
            vq  = (q / ht) % vt;
            er  = (hq < hv && vq < vv) ? (exp_addr(hq, vq, hv, vv) & 32'hfff) : 0;
            ehs = (hq >= hv + hf && hq < hv + hf + hsw) ? 0 : 1;
            evs = (vq >= vv + vf && vq < vv + vf + vsw) ? 0 : 1;
        end
        nbad = 0;
        if (oa   !== 19'(ea))  nbad++;
        if (orgb !== 12'(er))  nbad++;
        if (ohs  !== 1'(ehs))  nbad++;
        if (ovs  !== 1'(evs))  nbad++;
        if (ovb  !== 1'(evb))  nbad++;
        if (otk  !== 1'(etk))  nbad++;
    endtask

    // Directed sequence: reset, free run, mid-frame reset, restart.
    initial begin
        int nb, bad_a, bad_b, ticks_a, ticks_b;
        int hs_fall0, hs_fall1, hs_rise0, vs_fall0, vs_fall1, vs_rise0;
        int hs_fall_r, tick_first_b;
        logic prev_hs_a, prev_vs_b;

        compared   = 0;
        mismatched = 0;
        bad_a = 0; bad_b = 0; ticks_a = 0; ticks_b = 0;
        hs_fall0 = -1; hs_fall1 = -1; hs_rise0 = -1;
        vs_fall0 = -1; vs_fall1 = -1; vs_rise0 = -1;
        hs_fall_r = -1; tick_first_b = -1;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_addr_a",   32'(vram_addr_a), 32'd0);
        check("rst_rgb_a",    32'({vga_r_a, vga_g_a, vga_b_a}), 32'd0);
        check("rst_hs_a",     32'(vga_hs_a), 32'd1);
        check("rst_vs_a",     32'(vga_vs_a), 32'd1);
        check("rst_tick_a",   32'(frame_tick_a), 32'd0);
        check("rst_vblank_a", 32'(vblank_a), 32'd0);
        check("rst_addr_b",   32'(vram_addr_b), 32'd0);
        check("rst_vs_b",     32'(vga_vs_b), 32'd1);
        rst = 1'b0;

        prev_hs_a = 1'b1;
        prev_vs_b = 1'b1;
        for (int k = 1; k <= 7680; k++) begin
            @(posedge clk);
            #1;
            cycle_check(k, 4, 640, 16, 96, 48, 480, 10, 2, 33, vram_addr_a,
                        {vga_r_a, vga_g_a, vga_b_a}, vga_hs_a, vga_vs_a, vblank_a,
                        frame_tick_a, nb);
            bad_a += nb;
            cycle_check(k, 3, 8, 2, 3, 2, 4, 1, 2, 1, vram_addr_b,
                        {vga_r_b, vga_g_b, vga_b_b}, vga_hs_b, vga_vs_b, vblank_b,
                        frame_tick_b, nb);
            bad_b += nb;

            if (prev_hs_a && !vga_hs_a) begin
                if (hs_fall0 < 0) hs_fall0 = k;
                else if (hs_fall1 < 0) hs_fall1 = k;
            end
            if (!prev_hs_a && vga_hs_a && hs_rise0 < 0) hs_rise0 = k;
            if (prev_vs_b && !vga_vs_b) begin
                if (vs_fall0 < 0) vs_fall0 = k;
                else if (vs_fall1 < 0) vs_fall1 = k;
            end
            if (!prev_vs_b && vga_vs_b && vs_rise0 < 0) vs_rise0 = k;
            if (frame_tick_a) ticks_a++;
            if (frame_tick_b) ticks_b++;
            prev_hs_a = vga_hs_a;
            prev_vs_b = vga_vs_b;

            if (k == 24)   check("rgb_pix_5_0",    32'({vga_r_a, vga_g_a, vga_b_a}), 32'h005);
            if (k == 2556) check("addr_639_0",     32'(vram_addr_a), 32'd639);
            if (k == 2800) check("addr_hold_700_0", 32'(vram_addr_a), 32'd639);
            if (k == 2804) check("rgb_pix_700_0",  32'({vga_r_a, vga_g_a, vga_b_a}), 32'h000);
            if (k == 3196) check("addr_hold_799_0", 32'(vram_addr_a), 32'd639);
            if (k == 3200) check("addr_0_1",       32'(vram_addr_a), 32'd640);
            if (k == 3204) check("rgb_pix_0_1",    32'({vga_r_a, vga_g_a, vga_b_a}), 32'h280);
            if (k == 156)  check("addr_last_vis_b", 32'(vram_addr_b), 32'd31);
            if (k == 273)  check("rgb_vblank_b",   32'({vga_r_b, vga_g_b, vga_b_b}), 32'h000);
            if (k == 300)  check("addr_hold_vbl_b", 32'(vram_addr_b), 32'd31);
            if (k == 360)  check("addr_wrap_b",    32'(vram_addr_b), 32'd0);
        end

        check("hs_first_fall_a", 32'(hs_fall0), 32'd2628);
        check("hs_period_a",     32'(hs_fall1 - hs_fall0), 32'd3200);
        check("hs_low_a",        32'(hs_rise0 - hs_fall0), 32'd384);
        check("vs_first_fall_b", 32'(vs_fall0), 32'd228);
        check("vs_period_b",     32'(vs_fall1 - vs_fall0), 32'd360);
        check("vs_low_b",        32'(vs_rise0 - vs_fall0), 32'd90);
        check("tick_count_a",    32'(ticks_a), 32'd0);
        check("tick_count_b",    32'(ticks_b), 32'd21);

        // Mid-line reset on A at (320,2); B is mid-frame at (10,2).
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_addr_a", 32'(vram_addr_a), 32'd0);
        check("mid_rst_hs_a",   32'(vga_hs_a), 32'd1);
        check("mid_rst_vs_a",   32'(vga_vs_a), 32'd1);
        check("mid_rst_rgb_a",  32'({vga_r_a, vga_g_a, vga_b_a}), 32'd0);
        check("mid_rst_addr_b", 32'(vram_addr_b), 32'd0);
        check("mid_rst_tick_b", 32'(frame_tick_b), 32'd0);
        rst = 1'b0;

        prev_hs_a = 1'b1;
        for (int n = 1; n <= 3000; n++) begin
            @(posedge clk);
            #1;
            cycle_check(n, 4, 640, 16, 96, 48, 480, 10, 2, 33, vram_addr_a,
                        {vga_r_a, vga_g_a, vga_b_a}, vga_hs_a, vga_vs_a, vblank_a,
                        frame_tick_a, nb);
            bad_a += nb;
            cycle_check(n, 3, 8, 2, 3, 2, 4, 1, 2, 1, vram_addr_b,
                        {vga_r_b, vga_g_b, vga_b_b}, vga_hs_b, vga_vs_b, vblank_b,
                        frame_tick_b, nb);
            bad_b += nb;
            if (prev_hs_a && !vga_hs_a && hs_fall_r < 0) hs_fall_r = n;
            if (frame_tick_b && tick_first_b < 0) tick_first_b = n;
            prev_hs_a = vga_hs_a;
        end

        check("post_rst_hs_fall_a", 32'(hs_fall_r), 32'd2628);
        check("post_rst_tick_b",    32'(tick_first_b), 32'd180);
        check("cycle_model_a",      32'(bad_a), 32'd0);
        check("cycle_model_b",      32'(bad_b), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
